// File: rtl/timer8_ctrl.sv
// timer8_ctrl: 8-bit programmable interval timer with one-shot/periodic
// modes, pause/resume via start/stop and a valid/ready config port.
module timer8_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_period,
    input  logic       cfg_mode,
    output logic       cfg_ready,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] count,
    output logic       busy,
    output logic       tick,
    output logic       done,
    output logic       err,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

    logic [1:0] state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] period_q, period_d;
    logic       mode_q, mode_d;
    logic       tick_q, tick_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       at_term;
    logic       cfg_xfer;

    assign at_term  = (count_q == period_q);
    assign cfg_xfer = cfg_valid && (state_q == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= 8'd0;
            period_q <= 8'd0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && period_q != 8'd0)
                    state_d = S_RUN;
            end
            S_RUN: begin
                // completion of a one-shot takes priority over stop
                if (at_term && !mode_q)
                    state_d = S_IDLE;
                else if (stop)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (stop)
                    state_d = S_IDLE;
                else if (start)
                    state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                count_d = 8'd0;
                if (cfg_xfer) begin
                    period_d = cfg_period;
                    mode_d   = cfg_mode;
                end
                // start is judged against the period held before this edge
                if (start && period_q == 8'd0)
                    err_d = 1'b1;
            end
            S_RUN: begin
                if (at_term) begin
                    count_d = 8'd0;
                    tick_d  = 1'b1;
                    done_d  = !mode_q;
                end else if (!stop) begin
                    count_d = count_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (stop)
                    count_d = 8'd0;
            end
            default: count_d = 8'd0;
        endcase
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
    assign count     = count_q;
    assign tick      = tick_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_timer8_ctrl.sv
// Directed self-checking bench for timer8_ctrl.
module tb_timer8_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [7:0] cfg_period;
    logic       cfg_mode;
    logic       cfg_ready;
    logic       start;
    logic       stop;
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;
    logic       err;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    timer8_ctrl dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
        .start(start), .stop(stop),
        .count(count), .busy(busy), .tick(tick),
        .done(done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input logic [7:0] p, input logic m);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_mode   = m;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int t1, t2, mx;
        reset = 1'b0; cfg_valid = 1'b0; cfg_period = 8'd0;
        cfg_mode = 1'b0; start = 1'b0; stop = 1'b0;
        step(); step();
        chk("rst_state", state, 2'b00);
        chk("rst_count", count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_pulses", {tick, done, err}, 3'b000);
        reset = 1'b1;
        step();

        // start with no config -> err
        go();
        chk("nocfg_err", err, 1'b1);
        chk("nocfg_state", state, 2'b00);
        chk("nocfg_busy", busy, 1'b0);
        step();
        chk("nocfg_err_clr", err, 1'b0);

        // cfg + start in the same cycle: start sees old period 0
        cfg_valid = 1'b1; cfg_period = 8'd3; cfg_mode = 1'b1; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        chk("same_cyc_err", err, 1'b1);
        chk("same_cyc_state", state, 2'b00);

        // periodic, period 3
        go();
        chk("p3_state", state, 2'b01);
        chk("p3_cnt0", count, 8'd0);
        chk("p3_ready", cfg_ready, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("p3_cnt", count, i % 4);
            chk("p3_tick", tick, (i % 4) == 0);
            chk("p3_done", done, 1'b0);
        end
        // count now 2: stop -> HOLD frozen
        stop = 1'b1; step(); stop = 1'b0;
        chk("hold_state", state, 2'b10);
        chk("hold_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_cnt", count, 8'd2);
        end
        go();
        chk("resume_state", state, 2'b01);
        chk("resume_cnt", count, 8'd2);
        step();
        chk("resume_cnt3", count, 8'd3);
        step();
        chk("resume_wrap", count, 8'd0);
        chk("resume_tick", tick, 1'b1);
        step();
        chk("resume_cnt1", count, 8'd1);
        stop = 1'b1; step();
        chk("hold2_state", state, 2'b10);
        start = 1'b1; step();
        stop = 1'b0; start = 1'b0;
        chk("abort_state", state, 2'b00);
        chk("abort_cnt", count, 8'd0);
        chk("abort_pulses", {tick, done}, 2'b00);

        // stop at terminal, periodic, period 4
        cfg(8'd4, 1'b1);
        go();
        for (int i = 0; i < 4; i++) step();
        chk("st4p_cnt4", count, 8'd4);
        stop = 1'b1; step(); stop = 1'b0;
        chk("st4p_tick", tick, 1'b1);
        chk("st4p_state", state, 2'b10);
        chk("st4p_cnt", count, 8'd0);
        chk("st4p_done", done, 1'b0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("st4p_abort", state, 2'b00);

        // stop at terminal, one-shot, period 4
        cfg(8'd4, 1'b0);
        go();
        for (int i = 0; i < 4; i++) step();
        stop = 1'b1; step(); stop = 1'b0;
        chk("st4o_pulses", {tick, done}, 2'b11);
        chk("st4o_state", state, 2'b00);
        chk("st4o_ready", cfg_ready, 1'b1);

        // one-shot, period 5
        cfg(8'd5, 1'b0);
        go();
        chk("os5_cnt0", count, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("os5_cnt", count, i);
            chk("os5_done", done, 1'b0);
        end
        step();
        chk("os5_pulses", {tick, done}, 2'b11);
        chk("os5_state", state, 2'b00);
        chk("os5_cnt_end", count, 8'd0);
        chk("os5_ready", cfg_ready, 1'b1);
        step();
        chk("os5_pulse_clr", {tick, done}, 2'b00);

        // period 255 periodic; a cfg during RUN must be ignored
        cfg(8'd255, 1'b1);
        go();
        t1 = 0; t2 = 0; mx = 0;
        cfg_valid = 1'b1; cfg_period = 8'd2; cfg_mode = 1'b0;
        for (int n = 1; n <= 700 && t2 == 0; n++) begin
            step();
            cfg_valid = 1'b0;
            if (count > mx) mx = count;
            if (tick) begin
                if (t1 == 0) t1 = n;
                else t2 = n;
            end
        end
        chk("p255_first_tick", t1, 256);
        chk("p255_interval", t2 - t1, 256);
        chk("p255_max", mx, 255);
        chk("p255_state", state, 2'b01);
        for (int i = 0; i < 7; i++) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_state", state, 2'b00);
        chk("arst_count", count, 8'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", cfg_ready, 1'b1);
        chk("arst_pulses", {tick, done, err}, 3'b000);
        step();
        reset = 1'b1;
        step();
        go();
        chk("post_rst_err", err, 1'b1);
        chk("post_rst_state", state, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer8_ctrl.md
TIMER8_CTRL -- requirements
Module: timer8_ctrl

Interface
REQ-001 Parameters: none. Counter width is fixed at 8 bits.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset: 0 resets immediately, release is synchronous to clk.
REQ-004 cfg_valid  input  1  Configuration request; qualifies cfg_period and cfg_mode.
REQ-005 cfg_period  input  8  Terminal count value; legal range 1..255.
REQ-006 cfg_mode  input  1  0 = one-shot, 1 = periodic.
REQ-007 cfg_ready  output  1  High only in IDLE; a config transfer occurs on an edge where cfg_valid=1 and cfg_ready=1.
REQ-008 start  input  1  Level-sampled command: launch from IDLE, resume from HOLD.
REQ-009 stop  input  1  Level-sampled command: pause from RUN, abort from HOLD.
REQ-010 count  output  8  Current counter value (registered).
REQ-011 busy  output  1  High when state is RUN or HOLD.
REQ-012 tick  output  1  Registered one-cycle pulse on each terminal count.
REQ-013 done  output  1  Registered one-cycle pulse on one-shot completion.
REQ-014 err  output  1  Registered one-cycle pulse when start is rejected.
REQ-015 state  output  2  State encoding: IDLE=00, RUN=01, HOLD=10; 11 is unused and recovers to IDLE on the next edge.

Function
REQ-016 IDLE: on a cfg transfer, capture cfg_period into period_r and cfg_mode into mode_r on the same edge; count holds 0.
REQ-017 IDLE with start=1 and period_r!=0: next state RUN, count=0.
REQ-018 IDLE with start=1 and period_r==0: stay IDLE and pulse err for 1 cycle.
REQ-019 If a cfg transfer and start occur in the same IDLE cycle, capture the config and evaluate start against the OLD period_r.
REQ-020 RUN, not at terminal (count!=period_r): count increments by 1 per cycle.
REQ-021 RUN at terminal (count==period_r): next count=0 and tick=1 on the following cycle; the interval between ticks is exactly period_r+1 cycles.
REQ-022 Terminal in periodic mode (mode_r=1): remain in RUN.
REQ-023 Terminal in one-shot mode (mode_r=0): go to IDLE and assert done=1 together with tick=1.
REQ-024 RUN with stop=1 and not at terminal: go to HOLD; count freezes at its current value and no increment occurs.
REQ-025 RUN with stop=1 at terminal: tick is still issued and count goes to 0.
REQ-026 Stop at terminal, periodic mode: go to HOLD.
REQ-027 Stop at terminal, one-shot mode: go to IDLE with done=1; completion wins over stop.
REQ-028 HOLD with start=1 and stop=0: return to RUN; counting resumes from the frozen value on the next edge.
REQ-029 HOLD with stop=1: go to IDLE with count=0 and no tick or done; stop wins over a simultaneous start.
REQ-030 RUN with start=1: ignored. IDLE with stop=1: ignored.
REQ-031 cfg_ready=0 in RUN and HOLD; cfg_valid is ignored there and period_r/mode_r are unchanged.
REQ-032 count never exceeds period_r, so no 8-bit wrap occurs; period_r=255 gives a 256-cycle tick interval.
REQ-033 tick, done and err are single-cycle pulses and are never held across consecutive cycles except by back-to-back terminals at period_r=1? No: with period_r=1, ticks recur every 2 cycles.

Reset
REQ-034 While reset=0: state=IDLE, count=0, period_r=0, mode_r=0, tick=0, done=0, err=0, busy=0, cfg_ready=1.
REQ-035 Reset asserted mid-RUN or mid-HOLD aborts immediately with no done or tick pulse.
REQ-036 After release, the first start is rejected with err unless a config transfer has occurred first.

Verification
REQ-037 Reset, then start with no config -> err=1 for 1 cycle, state stays 00, busy=0.
REQ-038 Config period=3, mode=1, then start -> count sequence 0,1,2,3,0,1...; tick every 4 cycles, aligned with count returning to 0; done never asserts.
REQ-039 Config period=5, mode=0, then start -> count 0..5, then tick=1 and done=1 on the same cycle; state returns to 00 and cfg_ready=1.
REQ-040 Periodic run, stop when count=2 -> HOLD, count stays 2 for N cycles; start -> count 3 on the next edge; stop with start held in HOLD -> IDLE, count=0.
REQ-041 Stop coincident with terminal (period=4): periodic -> tick=1, HOLD, count=0; one-shot -> tick=1, done=1, IDLE.
REQ-042 Config period=255, mode=1 -> tick interval 256 cycles and count max 255; drive reset low mid-run -> all outputs return to reset values asynchronously.
